croc_sram_bank_arbiter: RTL and testbench
=========================================

Name: croc_sram_bank_arbiter

Overview:
- Shares one single-port SRAM bank between NumMgr OBI managers (debug, core instr, core data, user DMA).
- Round-robin arbitration, one grant per cycle, one-cycle read latency.
- In-order responses routed back to the granted manager only.
- Sits between the main xbar and each SRAM bank (default bank 0 at 0x1000_0000, 512 words). Out-of-range accesses get an OBI error response and never reach the SRAM.

Parameters:
- NumMgr, 4, number of requesting managers (min 2).
- IdWidth, 1, OBI aid/rid width per manager.
- BankBaseAddr, 32'h1000_0000, byte base address of the bank.
- BankNumWords, 512, bank depth in 32-bit words; AW = idx_width(BankNumWords).
- MaxHold, 4, max consecutive grants to one manager (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mgr_req_i  in  NumMgr  per-manager OBI req
- mgr_addr_i  in  NumMgr*32  byte addresses, manager i at [32i+:32]
- mgr_we_i  in  NumMgr  write enable
- mgr_be_i  in  NumMgr*4  byte enables
- mgr_wdata_i  in  NumMgr*32  write data
- mgr_aid_i  in  NumMgr*IdWidth  transaction id
- mgr_gnt_o  out  NumMgr  one-hot or zero grant
- mgr_rvalid_o  out  NumMgr  one-hot or zero response valid
- mgr_rdata_o  out  32  shared read data
- mgr_rid_o  out  IdWidth  shared response id
- mgr_err_o  out  1  shared response error
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write
- sram_addr_o  out  AW  SRAM word index = addr[AW+1:2] - base word
- sram_be_o  out  4  SRAM byte enables
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  1*32  SRAM read data, valid the cycle after sram_req_o

Behaviour:
Arbitration:
- Combinational round-robin over mgr_req_i, starting at priority pointer prio_q (reset 0).
- Winner w gets mgr_gnt_o[w]=1 in the same cycle its req is high. The SRAM is always ready, so at most one grant per cycle and none when no req.
- After a grant: prio_q <= (w+1) mod NumMgr. With no grant, prio_q holds.

Range check:
- in_range = addr >= BankBaseAddr && addr < BankBaseAddr + BankNumWords*4, computed in 33-bit arithmetic so there is no wrap at 0xFFFF_FFFC.
- Granted and in range: sram_req_o=1; we/be/wdata/addr forwarded.
- Granted and out of range: sram_req_o=0; the error is recorded.
- Address bits [1:0] are ignored.

Response pipeline (registered):
- rsp_valid_q, rsp_idx_q, rsp_id_q, rsp_err_q, loaded on every grant.
- Cycle N+1 after grant: mgr_rvalid_o[rsp_idx_q]=1; mgr_rid_o=rsp_id_q; mgr_err_o=rsp_err_q.
- mgr_rdata_o = rsp_err_q ? 32'h0 : sram_rdata_i. Writes also return rvalid; rdata is don't-care.
- Back-to-back grants produce back-to-back rvalids, one per cycle. No rready, no stall.

Reset values:
- All *_o = 0. prio_q=0, rsp_valid_q=0, hold counter=0.
- Reset asserted mid-transaction drops the pending response; no rvalid is issued after reset release for pre-reset grants.

Simultaneous events:
- A grant in cycle N and the rvalid for the N-1 grant coexist; the response is that of N-1.
- A request withdrawn without a grant is legal and leaves no state.

Optional Feature:
CROC_SRAM_ARB_HOLD_EN
- Defined: the last winner keeps priority while it keeps requesting, up to MaxHold consecutive grants.
  - Counter hold_q (width idx_width(MaxHold+1)) increments on each consecutive grant to the same manager.
  - On reaching MaxHold, or when that manager drops req, prio_q advances to winner+1 and hold_q resets to 0.
  - Intended for burst-friendly DMA from the user domain.
- Undefined: pure round-robin as above; hold_q and MaxHold are unused and no counter is synthesized.

Test Plan:
- Single read: mgr 2 reads 0x1000_0010 with aid=1, SRAM word 4 = 0xDEAD_BEEF -> gnt[2] same cycle, sram_addr_o=4, next cycle rvalid[2]=1, rdata=0xDEAD_BEEF, rid=1, err=0.
- All 4 managers request continuously for 8 cycles (no hold) -> grant order 0,1,2,3,0,1,2,3; rvalid follows one cycle later with matching index.
- Out-of-range: mgr 1 writes 0x1000_0800 -> gnt[1]=1, sram_req_o=0, next cycle rvalid[1]=1, err=1, rdata=0. Also 0x0FFF_FFFC -> err=1.
- Write then read: mgr 3 writes be=4'b0011, wdata=0x1234_5678 to word 7 -> sram_we_o=1, sram_be_o=0011; a following read returns the memory model's merged value, err=0.
- Reset mid-flight: grant to mgr 0 in cycle N, rst_ni low in cycle N+1 -> all outputs 0; after release, no rvalid and prio_q=0.
- With CROC_SRAM_ARB_HOLD_EN and MaxHold=4: mgr 0 and mgr 1 both requesting -> grants 0,0,0,0,1,1,1,1,0…; when mgr 0 drops req after 2 grants, mgr 1 is granted the next cycle.

Source files
------------

// File: rtl/croc_sram_bank_arbiter.sv
// croc_sram_bank_arbiter: shares one single-port SRAM bank between NumMgr OBI managers.
// Round-robin arbitration with one grant per cycle. Read latency is one cycle, and responses
// return in order. An access outside the bank's address window gets an OBI error response and
// never reaches the SRAM.
// Optional feature macro: CROC_SRAM_ARB_HOLD_EN. When it is defined, the last winner keeps
// priority for up to MaxHold consecutive grants.
module croc_sram_bank_arbiter #(
  parameter int unsigned NumMgr       = 4,
  parameter int unsigned IdWidth      = 1,
  parameter logic [31:0] BankBaseAddr = 32'h1000_0000,
  parameter int unsigned BankNumWords = 512,
  parameter int unsigned MaxHold      = 4,
  localparam int unsigned AW          = (BankNumWords > 1) ? $clog2(BankNumWords) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumMgr-1:0]         mgr_req_i,
  input  logic [NumMgr*32-1:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]         mgr_we_i,
  input  logic [NumMgr*4-1:0]       mgr_be_i,
  input  logic [NumMgr*32-1:0]      mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0] mgr_aid_i,
  output logic [NumMgr-1:0]         mgr_gnt_o,
  output logic [NumMgr-1:0]         mgr_rvalid_o,
  output logic [31:0]               mgr_rdata_o,
  output logic [IdWidth-1:0]        mgr_rid_o,
  output logic                      mgr_err_o,
  output logic                      sram_req_o,
  output logic                      sram_we_o,
  output logic [AW-1:0]             sram_addr_o,
  output logic [3:0]                sram_be_o,
  output logic [31:0]               sram_wdata_o,
  input  logic [31:0]               sram_rdata_i
);

  localparam int unsigned PW       = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  // 33-bit window bounds so a bank ending at the top of the address map does not wrap.
  localparam logic [32:0] BaseExt  = {1'b0, BankBaseAddr};
  localparam logic [32:0] LimitExt = BaseExt + 33'(BankNumWords) * 33'd4;

  logic [PW-1:0]      prio_q, prio_d;
  logic [NumMgr-1:0]  req_eff;
  logic               gnt_valid;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      win_next;
  logic [31:0]        win_addr;
  logic [32:0]        win_addr_ext;
  logic               in_range;

  logic               rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]      rsp_idx_q, rsp_idx_d;
  logic [IdWidth-1:0] rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;

  // Round-robin pick: the first requester at or after prio_q wins. Requests are masked while
  // reset is asserted so every output stays low during reset.
  always_comb begin
    logic [PW:0] cand;
    req_eff   = rst_ni ? mgr_req_i : '0;
    gnt_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumMgr; k++) begin
      cand = {1'b0, prio_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NumMgr)) begin
        cand = cand - (PW+1)'(NumMgr);
      end
      if (!gnt_valid && req_eff[cand[PW-1:0]]) begin
        gnt_valid = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
    win_next = (win_idx == PW'(NumMgr - 1)) ? '0 : win_idx + 1'b1;
  end

  // Grant vector and range check of the winning manager's address (byte offset ignored).
  always_comb begin
    mgr_gnt_o = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      mgr_gnt_o[i] = gnt_valid && (win_idx == PW'(i));
    end
    win_addr     = mgr_addr_i[int'(win_idx)*32 +: 32];
    win_addr_ext = {1'b0, win_addr[31:2], 2'b00};
    in_range     = (win_addr_ext >= BaseExt) && (win_addr_ext < LimitExt);
  end

  // SRAM port: driven only for granted in-range accesses, otherwise held at zero.
  always_comb begin
    sram_req_o   = gnt_valid && in_range;
    sram_we_o    = sram_req_o && mgr_we_i[win_idx];
    sram_be_o    = sram_req_o ? mgr_be_i[int'(win_idx)*4 +: 4] : 4'h0;
    sram_wdata_o = sram_req_o ? mgr_wdata_i[int'(win_idx)*32 +: 32] : 32'h0;
    sram_addr_o  = sram_req_o ? AW'((win_addr_ext - BaseExt) >> 2) : '0;
  end

  // Response pipeline next state: every grant yields exactly one response next cycle.
  always_comb begin
    rsp_valid_d = gnt_valid;
    rsp_idx_d   = gnt_valid ? win_idx : rsp_idx_q;
    rsp_id_d    = gnt_valid ? mgr_aid_i[int'(win_idx)*IdWidth +: IdWidth] : rsp_id_q;
    rsp_err_d   = gnt_valid ? !in_range : rsp_err_q;
  end

`ifdef CROC_SRAM_ARB_HOLD_EN
  localparam int unsigned HW = ((MaxHold + 1) > 1) ? $clog2(MaxHold + 1) : 1;

  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] prio_inc;

  // Priority with hold: the holder keeps prio_q until MaxHold grants or until it drops req.
  always_comb begin
    prio_d   = prio_q;
    hold_d   = hold_q;
    hold_cnt = '0;
    prio_inc = (prio_q == PW'(NumMgr - 1)) ? '0 : prio_q + 1'b1;
    if (gnt_valid) begin
      hold_cnt = ((hold_q != '0) && (win_idx == prio_q)) ? hold_q + 1'b1 : HW'(1);
      if (hold_cnt >= HW'(MaxHold)) begin
        prio_d = win_next;
        hold_d = '0;
      end else begin
        prio_d = win_idx;
        hold_d = hold_cnt;
      end
    end else if ((hold_q != '0) && !req_eff[prio_q]) begin
      prio_d = prio_inc;
      hold_d = '0;
    end
  end

  // Hold counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Pure round-robin: after a grant the winner moves to the back of the line.
  always_comb begin
    prio_d = gnt_valid ? win_next : prio_q;
  end

  // MaxHold only matters with the hold feature; this empty block keeps it referenced.
  if (MaxHold == 0) begin : gen_no_hold
  end
`endif

  // Priority pointer and response pipeline state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Response outputs: routed to the granted manager only; error responses return zero data.
  always_comb begin
    mgr_rvalid_o = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      mgr_rvalid_o[i] = rsp_valid_q && (rsp_idx_q == PW'(i));
    end
    mgr_rid_o   = rsp_valid_q ? rsp_id_q : '0;
    mgr_err_o   = rsp_valid_q && rsp_err_q;
    mgr_rdata_o = (rsp_valid_q && !rsp_err_q) ? sram_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_croc_sram_bank_arbiter.sv
// Self-checking bench for croc_sram_bank_arbiter. It uses table-driven single transactions,
// then hand-written sequences for round-robin order, reset mid-flight and (optionally) hold.
module tb_croc_sram_bank_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   mgr_req, mgr_we, mgr_aid;
  logic [127:0] mgr_addr, mgr_wdata;
  logic [15:0]  mgr_be;
  logic [3:0]   mgr_gnt, mgr_rvalid;
  logic [31:0]  mgr_rdata;
  logic [0:0]   mgr_rid;
  logic         mgr_err;
  logic         sram_req, sram_we;
  logic [8:0]   sram_addr;
  logic [3:0]   sram_be;
  logic [31:0]  sram_wdata;
  logic [31:0]  sram_rdata;

  logic [31:0]  mem [512];
  bit           loaded;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  croc_sram_bank_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mgr_req_i    (mgr_req),
    .mgr_addr_i   (mgr_addr),
    .mgr_we_i     (mgr_we),
    .mgr_be_i     (mgr_be),
    .mgr_wdata_i  (mgr_wdata),
    .mgr_aid_i    (mgr_aid),
    .mgr_gnt_o    (mgr_gnt),
    .mgr_rvalid_o (mgr_rvalid),
    .mgr_rdata_o  (mgr_rdata),
    .mgr_rid_o    (mgr_rid),
    .mgr_err_o    (mgr_err),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_be_o    (sram_be),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  // SRAM model: byte-merged writes and a one-cycle read latency, preloaded on the first edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h0BAD_F00D;
      mem[4]   <= 32'hDEAD_BEEF;
      mem[7]   <= 32'hAABB_CCDD;
      mem[511] <= 32'h5A5A_0001;
      loaded   <= 1'b1;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    int          mgr;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        exp_sreq;
    logic [8:0]  exp_saddr;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    mgr_req = '0; mgr_we = '0; mgr_aid = '0; mgr_be = '0;
    mgr_addr = '0; mgr_wdata = '0;
  endtask

  task automatic drive(input int m, input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic aid);
    mgr_req[m]          = 1'b1;
    mgr_we[m]           = we;
    mgr_aid[m]          = aid;
    mgr_be[4*m +: 4]    = be;
    mgr_addr[32*m +: 32]  = addr;
    mgr_wdata[32*m +: 32] = wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},      32'(mgr_gnt),    32'h0);
    chk({tag, " rvalid"},   32'(mgr_rvalid), 32'h0);
    chk({tag, " rdata"},    mgr_rdata,       32'h0);
    chk({tag, " rid"},      32'(mgr_rid),    32'h0);
    chk({tag, " err"},      32'(mgr_err),    32'h0);
    chk({tag, " sram_req"}, 32'(sram_req),   32'h0);
  endtask

`ifdef CROC_SRAM_ARB_HOLD_EN
  int hold_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

  initial begin
    //       mgr addr           we    be     wdata          aid  sreq saddr err  chkrd rdata
    vecs[0] = '{2, 32'h1000_0010, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 9'd4,   1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1, 32'h1000_0800, 1'b1, 4'hF, 32'hCAFE_0000, 1'b0, 1'b0, 9'd0,   1'b1, 1'b1, 32'h0};
    vecs[2] = '{0, 32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 9'd0,   1'b1, 1'b1, 32'h0};
    vecs[3] = '{3, 32'h1000_001C, 1'b1, 4'h3, 32'h1234_5678, 1'b0, 1'b1, 9'd7,   1'b0, 1'b0, 32'h0};
    vecs[4] = '{3, 32'h1000_001C, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 9'd7,   1'b0, 1'b1, 32'hAABB_5678};
    vecs[5] = '{1, 32'h1000_07FF, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 9'd511, 1'b0, 1'b1, 32'h5A5A_0001};
    vecs[6] = '{0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 9'd0,   1'b1, 1'b1, 32'h0};
    vecs[7] = '{2, 32'h1000_0000, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 9'd0,   1'b0, 1'b1, 32'h0BAD_F00D};

    // Reset: outputs must be zero even while every manager is requesting.
    idle();
    mgr_req = 4'hF;
    mgr_addr = {4{32'h1000_0000}};
    @(negedge clk);
    @(negedge clk);
    #1 chk_all_zero("reset");
    idle();
    @(negedge clk);
    rst_ni = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      drive(vecs[i].mgr, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, vecs[i].aid);
      #1;
      chk($sformatf("v%0d gnt", i), 32'(mgr_gnt), 32'(4'b0001 << vecs[i].mgr));
      chk($sformatf("v%0d sram_req", i), 32'(sram_req), 32'(vecs[i].exp_sreq));
      chk($sformatf("v%0d sram_we", i), 32'(sram_we), 32'(vecs[i].exp_sreq & vecs[i].we));
      if (vecs[i].exp_sreq) begin
        chk($sformatf("v%0d sram_addr", i), 32'(sram_addr), 32'(vecs[i].exp_saddr));
        chk($sformatf("v%0d sram_be", i), 32'(sram_be), 32'(vecs[i].be));
        if (vecs[i].we) chk($sformatf("v%0d sram_wdata", i), sram_wdata, vecs[i].wdata);
      end
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("v%0d rvalid", i), 32'(mgr_rvalid), 32'(4'b0001 << vecs[i].mgr));
      chk($sformatf("v%0d rid", i), 32'(mgr_rid), 32'(vecs[i].aid));
      chk($sformatf("v%0d err", i), 32'(mgr_err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdata) chk($sformatf("v%0d rdata", i), mgr_rdata, vecs[i].exp_rdata);
    end

    // All four managers request continuously: grants 0,1,2,3,0,1,2,3; rvalid one cycle behind.
    do_reset();
    for (int m = 0; m < 4; m++) drive(m, 32'h1000_0000 + 32'(4 * m), 1'b0, 4'hF, 32'h0, m[0]);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d gnt", k), 32'(mgr_gnt), 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr%0d rvalid", k), 32'(mgr_rvalid), 32'(4'b0001 << ((k - 1) % 4)));
        chk($sformatf("rr%0d rid", k), 32'(mgr_rid), 32'((k - 1) % 2));
      end
      @(negedge clk);
    end
    idle();
    #1 chk("rr tail rvalid", 32'(mgr_rvalid), 32'h8);

    // Reset mid-flight: the pending response is dropped and priority returns to manager 0.
    do_reset();
    drive(0, 32'h1000_0010, 1'b0, 4'hF, 32'h0, 1'b1);
    #1 chk("mid gnt", 32'(mgr_gnt), 32'h1);
    @(negedge clk);
    idle();
    rst_ni = 1'b0;
    #1 chk_all_zero("mid rst");
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mid post%0d rvalid", k), 32'(mgr_rvalid), 32'h0);
      @(negedge clk);
    end
    drive(0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    drive(1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0);
    #1 chk("mid prio gnt", 32'(mgr_gnt), 32'h1);
    @(negedge clk);
    idle();

`ifdef CROC_SRAM_ARB_HOLD_EN
    // Hold: managers 0 and 1 requesting with MaxHold=4.
    do_reset();
    drive(0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    drive(1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      #1 chk($sformatf("hold%0d gnt", k), 32'(mgr_gnt), 32'(4'b0001 << hold_seq[k]));
      @(negedge clk);
    end
    idle();
    // Holder drops req after two grants: manager 1 wins the next cycle.
    do_reset();
    drive(0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    drive(1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0);
    #1 chk("drop g0", 32'(mgr_gnt), 32'h1);
    @(negedge clk);
    #1 chk("drop g1", 32'(mgr_gnt), 32'h1);
    @(negedge clk);
    mgr_req[0] = 1'b0;
    #1 chk("drop g2", 32'(mgr_gnt), 32'h2);
    @(negedge clk);
    idle();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
